// File: rtl/line_clear_ctrl_if.sv
// rtl/line_clear_ctrl_if.sv - board memory bus between line_clear_ctrl and the board RAM
//
// Signals:
//   mem_wnr    write enable (controller -> memory)
//   mem_rowid  row address   (controller -> memory)
//   mem_wdata  write data    (controller -> memory)
//   mem_rdata  read data     (memory -> controller), combinational from mem_rowid
interface line_clear_ctrl_if #(
    parameter int COLS = 20
);
    logic            mem_wnr;
    logic [4:0]      mem_rowid;
    logic [COLS-1:0] mem_wdata;
    logic [COLS-1:0] mem_rdata;

    modport master (
        output mem_wnr,
        output mem_rowid,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_wnr,
        input  mem_rowid,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - removes full board rows and compacts the rest downward
//
// Ports:
//   clk            single clock, all state updates on its rising edge
//   reset_n        asynchronous active-low reset
//   start          request one pass; only looked at in IDLE
//   busy           high in every state except IDLE
//   done           one-cycle pulse at the end of a pass
//   lines_cleared  full rows removed by the most recent pass
//   mem            board memory bus (master side)
module line_clear_ctrl #(
    parameter int ROWS = 20,
    parameter int COLS = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared,
    line_clear_ctrl_if.master mem
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        FILL,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [4:0]      rd_ptr;
    logic [4:0]      wr_ptr;
    logic [4:0]      cnt;
    logic [COLS-1:0] row_buf;
    logic            row_full;

    assign row_full = &mem.mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        busy          = (state != IDLE);
        done          = 1'b0;
        mem.mem_wnr   = 1'b0;
        mem.mem_rowid = 5'd0;
        mem.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                end
            end
            READ: begin
                mem.mem_rowid = rd_ptr;
                if (row_full) begin
                    // Full rows are dropped: no write, just move to the next row up.
                    if (rd_ptr == 5'd0) begin
                        state_nx = FILL;
                    end
                end else begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                mem.mem_wnr   = 1'b1;
                mem.mem_rowid = wr_ptr;
                mem.mem_wdata = row_buf;
                state_nx      = (rd_ptr == 5'd0) ? FILL : READ;
            end
            FILL: begin
                if (cnt == 5'd0) begin
                    state_nx = DONE;
                end else begin
                    mem.mem_wnr   = 1'b1;
                    mem.mem_rowid = wr_ptr;
                    if (wr_ptr == 5'd0) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr        <= 5'd0;
            wr_ptr        <= 5'd0;
            cnt           <= 5'd0;
            row_buf       <= '0;
            lines_cleared <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr <= 5'(ROWS - 1);
                        wr_ptr <= 5'(ROWS - 1);
                        cnt    <= 5'd0;
                    end
                end
                READ: begin
                    row_buf <= mem.mem_rdata;
                    if (row_full) begin
                        cnt <= cnt + 5'd1;
                        if (rd_ptr != 5'd0) begin
                            rd_ptr <= rd_ptr - 5'd1;
                        end
                    end
                end
                WRITE: begin
                    // wr_ptr never trails rd_ptr, so it only reaches 0 on the last row.
                    if (wr_ptr != 5'd0) begin
                        wr_ptr <= wr_ptr - 5'd1;
                    end
                    if (rd_ptr != 5'd0) begin
                        rd_ptr <= rd_ptr - 5'd1;
                    end
                end
                FILL: begin
                    if (cnt != 5'd0 && wr_ptr != 5'd0) begin
                        wr_ptr <= wr_ptr - 5'd1;
                    end
                    // Loaded as DONE is entered so the count is valid alongside done.
                    if (state_nx == DONE) begin
                        lines_cleared <= cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - self-checking bench for line_clear_ctrl
module tb_line_clear_ctrl;

    localparam int ROWS = 20;
    localparam int COLS = 20;
    localparam int NVEC = 6;

    typedef struct {
        logic [COLS-1:0] init [ROWS];
        logic [COLS-1:0] exp  [ROWS];
        logic [4:0]      lines;
        int              len;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;

    logic [COLS-1:0] mem [ROWS];
    logic [COLS-1:0] img [ROWS];
    logic            load = 1'b0;
    int              wr_count = 0;

    int tests = 0;
    int fails = 0;

    vec_t vecs [NVEC];

    line_clear_ctrl_if #(.COLS(COLS)) bus ();

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .mem           (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = (bus.mem_rowid < 5'(ROWS)) ? mem[bus.mem_rowid] : '0;

    always @(posedge clk) begin
        if (load) begin
            mem <= img;
        end else if (bus.mem_wnr) begin
            mem[bus.mem_rowid] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_vec(input int v);
        img = vecs[v].init;
        @(negedge clk);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic check_board(input string tag, input int v);
        for (int r = 0; r < ROWS; r++) begin
            chk($sformatf("%s row %0d", tag, r), 32'(mem[r]), 32'(vecs[v].exp[r]));
        end
    endtask

    // Runs one pass from a start pulse; poke > 0 re-pulses start at that cycle of the pass.
    task automatic run_pass(input string tag, input int exp_len, input logic [4:0] exp_lines,
                            input int poke);
        int n;
        int w0;
        n  = 0;
        w0 = wr_count;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            start = (n == poke);
            if (n == 1) begin
                chk({tag, " busy in pass"}, 32'(busy), 32'd1);
            end
            if (done) break;
        end
        start = 1'b0;
        chk({tag, " pass length"}, 32'(n), 32'(exp_len));
        @(negedge clk);
        chk({tag, " done single pulse"}, 32'(done), 32'd0);
        chk({tag, " idle after done"}, 32'(busy), 32'd0);
        chk({tag, " lines_cleared"}, 32'(lines_cleared), 32'(exp_lines));
        chk({tag, " write count"}, 32'(wr_count - w0), 32'(ROWS));
    endtask

    initial begin
        int d_cyc [3];
        int nd;
        int c;
        int w;

        for (int v = 0; v < NVEC; v++) begin
            for (int r = 0; r < ROWS; r++) begin
                vecs[v].init[r] = '0;
                vecs[v].exp[r]  = '0;
            end
        end
        // 0: empty board
        vecs[0].lines = 5'd0;  vecs[0].len = 42;
        // 1: bottom row full, one pixel above it
        vecs[1].init[19] = 20'hFFFFF; vecs[1].init[18] = 20'h00001;
        vecs[1].exp[19]  = 20'h00001;
        vecs[1].lines = 5'd1;  vecs[1].len = 41;
        // 2: three full rows interleaved with data
        vecs[2].init[19] = 20'hFFFFF; vecs[2].init[17] = 20'hFFFFF; vecs[2].init[5] = 20'hFFFFF;
        vecs[2].init[18] = 20'h0000F; vecs[2].init[16] = 20'h000F0;
        vecs[2].exp[19]  = 20'h0000F; vecs[2].exp[18]  = 20'h000F0;
        vecs[2].lines = 5'd3;  vecs[2].len = 41;
        // 3: every row full
        for (int r = 0; r < ROWS; r++) vecs[3].init[r] = 20'hFFFFF;
        vecs[3].lines = 5'd20; vecs[3].len = 41;
        // 4: even rows full, odd row r holds r; survivors land in rows 10..19 as 2j-19
        for (int r = 0; r < ROWS; r++) vecs[4].init[r] = (r % 2 == 0) ? 20'hFFFFF : 20'(r);
        for (int j = 10; j < ROWS; j++) vecs[4].exp[j] = 20'(2 * j - 19);
        vecs[4].lines = 5'd10; vecs[4].len = 41;
        // 5: only the top row full, distinct data elsewhere stays in place
        for (int r = 1; r < ROWS; r++) begin
            vecs[5].init[r] = 20'h01000 + 20'(r);
            vecs[5].exp[r]  = 20'h01000 + 20'(r);
        end
        vecs[5].init[0] = 20'hFFFFF;
        vecs[5].lines = 5'd1;  vecs[5].len = 41;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset mem_wnr", 32'(bus.mem_wnr), 32'd0);
        chk("reset mem_rowid", 32'(bus.mem_rowid), 32'd0);
        chk("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("reset lines_cleared", 32'(lines_cleared), 32'd0);
        reset_n = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            load_vec(v);
            run_pass($sformatf("v%0d", v), vecs[v].len, vecs[v].lines, 0);
            check_board($sformatf("v%0d", v), v);
        end

        // start pulsed while busy is ignored
        load_vec(1);
        run_pass("poke", 41, 5'd1, 5);
        check_board("poke", 1);
        repeat (3) begin
            @(negedge clk);
            chk("poke not queued", 32'(busy), 32'd0);
        end

        // start held high: back-to-back passes, one idle cycle between them
        load_vec(0);
        @(negedge clk);
        start = 1'b1;
        nd = 0;
        c  = 0;
        while (nd < 3 && c < 400) begin
            @(negedge clk);
            c++;
            if (done) begin
                d_cyc[nd] = c;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held start done count", 32'(nd), 32'd3);
        if (nd == 3) begin
            chk("held start period 1", 32'(d_cyc[1] - d_cyc[0]), 32'd43);
            chk("held start period 2", 32'(d_cyc[2] - d_cyc[1]), 32'd43);
        end
        @(negedge clk);
        chk("held start released", 32'(busy), 32'd0);

        // Reset at cycle 10 of a pass
        load_vec(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset mem_wnr", 32'(bus.mem_wnr), 32'd0);
        chk("midreset mem_rowid", 32'(bus.mem_rowid), 32'd0);
        chk("midreset lines_cleared", 32'(lines_cleared), 32'd0);
        w = wr_count;
        @(posedge clk);
        #1;
        chk("midreset no write", 32'(wr_count - w), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        load_vec(1);
        run_pass("after reset", 41, 5'd1, 0);
        check_board("after reset", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
